// File: rtl/intcode_io_pkg.sv
// Shared constants for the Intcode memory-mapped I/O port: default
// register addresses and the bit layout of the status word.
package intcode_io_pkg;

    localparam logic [31:0] DefInAddr   = 32'hFFFF0000;
    localparam logic [31:0] DefOutAddr  = 32'hFFFF0001;
    localparam logic [31:0] DefStatAddr = 32'hFFFF0002;

    localparam int unsigned StatInEmpty  = 0;
    localparam int unsigned StatOutFull  = 1;
    localparam int unsigned StatErrUnder = 2;
    localparam int unsigned StatErrOver  = 3;
    localparam int unsigned StatIrqEn    = 4;
    localparam int unsigned StatFlagBits = 5;
    localparam int unsigned StatPadBits  = 12;

endpackage

// File: rtl/intcode_io_port_if.sv
// CPU bus plus host-side streaming channels of the I/O port.
interface intcode_io_port_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      address_bus;
    logic             ram_write;
    logic             bus_rd;
    logic [WIDTH-1:0] bus_wdata;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_rdata_oe;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             irq;

    modport master (
        output address_bus, ram_write, bus_rd, bus_wdata, in_data, in_valid, out_ready,
        input  bus_rdata, bus_rdata_oe, in_ready, out_data, out_valid, irq
    );

    modport slave (
        input  address_bus, ram_write, bus_rd, bus_wdata, in_data, in_valid, out_ready,
        output bus_rdata, bus_rdata_oe, in_ready, out_data, out_valid, irq
    );
endinterface

// File: rtl/intcode_fifo.sv
// Power-of-two synchronous FIFO; push when full and pop when empty are ignored,
// head is read combinationally from storage.
module intcode_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    // Gating against the registered count keeps a pop from empty from seeing a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/intcode_io_port.sv
// Memory-mapped I/O port: input FIFO read by the CPU, output FIFO written by the CPU,
// plus a status/control register with sticky error flags and a level interrupt.
module intcode_io_port
    import intcode_io_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] IN_ADDR   = DefInAddr,
    parameter logic [31:0] OUT_ADDR  = DefOutAddr,
    parameter logic [31:0] STAT_ADDR = DefStatAddr
) (
    input  logic               clock,
    input  logic               reset,
    intcode_io_port_if.slave   bus
);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned StatW = 2 * CntW + StatPadBits + StatFlagBits;

    logic             in_full, in_empty, out_full, out_empty;
    logic [CntW-1:0]  in_count, out_count;
    logic [WIDTH-1:0] in_head, out_head;
    logic             in_push, in_pop, out_push, out_pop, in_ready;
    logic             sel_in, sel_out, sel_stat, rd_cycle, out_wr;
    logic [StatW-1:0] stat_raw;

    logic             run_q;
    logic             irq_en_q, irq_en_d;
    logic             err_under_q, err_under_d;
    logic             err_over_q, err_over_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    assign sel_in   = (bus.address_bus == IN_ADDR);
    assign sel_out  = (bus.address_bus == OUT_ADDR);
    assign sel_stat = (bus.address_bus == STAT_ADDR);
    assign rd_cycle = bus.bus_rd && !bus.ram_write;
    assign out_wr   = bus.ram_write && sel_out;

    // run_q holds in_ready low through reset and for the first edge after it.
    assign in_ready = run_q && !in_full;
    assign in_push  = bus.in_valid && in_ready;
    assign in_pop   = rd_cycle && sel_in && !in_empty;
    assign out_push = out_wr && !out_full;
    assign out_pop  = !out_empty && bus.out_ready;

    assign stat_raw = {in_count, out_count, {StatPadBits{1'b0}},
                       irq_en_q, err_over_q, err_under_q, out_full, in_empty};

    intcode_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (bus.in_data),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count),
        .head  (in_head)
    );

    intcode_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (bus.bus_wdata),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count),
        .head  (out_head)
    );

    always_comb begin
        irq_en_d    = irq_en_q;
        err_under_d = err_under_q;
        err_over_d  = err_over_q;
        rdata_d     = rdata_q;

        if (bus.ram_write && sel_stat) begin
            irq_en_d = bus.bus_wdata[StatIrqEn];
            if (bus.bus_wdata[StatErrUnder]) err_under_d = 1'b0;
            if (bus.bus_wdata[StatErrOver])  err_over_d  = 1'b0;
        end
        // A new error event wins over a same-cycle clear.
        if (out_wr && out_full) err_over_d = 1'b1;

        if (rd_cycle) begin
            if (sel_in) begin
                rdata_d = in_empty ? '0 : in_head;
                if (in_empty) err_under_d = 1'b1;
            end else if (sel_out) begin
                rdata_d = '0;
            end else if (sel_stat) begin
                rdata_d = WIDTH'(stat_raw);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            run_q       <= 1'b1;
            irq_en_q    <= irq_en_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.bus_rdata    = rdata_q;
    assign bus.bus_rdata_oe = rd_cycle && (sel_in || sel_out || sel_stat);
    assign bus.in_ready     = in_ready;
    assign bus.out_data     = out_head;
    assign bus.out_valid    = !out_empty;
    assign bus.irq          = irq_en_q && !in_empty;

endmodule

// File: tb/tb_intcode_io_port.sv
// Directed bench for intcode_io_port: a vector table for single-cycle bus behaviour
// followed by hand-written fill/drain, wrap and reset sequences.
module tb_intcode_io_port;

    localparam logic [31:0] AIn  = 32'hFFFF0000;
    localparam logic [31:0] AOut = 32'hFFFF0001;
    localparam logic [31:0] ASt  = 32'hFFFF0002;
    localparam logic [31:0] AX   = 32'h00001234;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] idata;
        logic        ival;
        logic        ordy;
        logic        chk_od;
        logic [31:0] exp_od;
        logic        exp_oe;
        logic [31:0] exp_rdata;
        logic        exp_ir;
        logic        exp_ov;
        logic        exp_irq;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[18];

    intcode_io_port_if #(.WIDTH(32)) bus_if ();

    intcode_io_port #(.WIDTH(32), .DEPTH(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus_if.address_bus = AX;
        bus_if.ram_write   = 1'b0;
        bus_if.bus_rd      = 1'b0;
        bus_if.bus_wdata   = '0;
        bus_if.in_data     = '0;
        bus_if.in_valid    = 1'b0;
        bus_if.out_ready   = 1'b0;
    endtask

    task automatic cpu_rd(input logic [31:0] addr);
        bus_if.address_bus = addr;
        bus_if.bus_rd      = 1'b1;
        bus_if.ram_write   = 1'b0;
    endtask

    task automatic cpu_wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.address_bus = addr;
        bus_if.bus_rd      = 1'b0;
        bus_if.ram_write   = 1'b1;
        bus_if.bus_wdata   = data;
    endtask

    function automatic vec_t mk(
        input logic [31:0] addr, input logic wr, input logic rd, input logic [31:0] wdata,
        input logic [31:0] idata, input logic ival, input logic ordy, input logic chk_od,
        input logic [31:0] exp_od, input logic exp_oe, input logic [31:0] exp_rdata,
        input logic exp_ir, input logic exp_ov, input logic exp_irq);
        vec_t v;
        v.addr = addr; v.wr = wr; v.rd = rd; v.wdata = wdata; v.idata = idata;
        v.ival = ival; v.ordy = ordy; v.chk_od = chk_od; v.exp_od = exp_od;
        v.exp_oe = exp_oe; v.exp_rdata = exp_rdata; v.exp_ir = exp_ir;
        v.exp_ov = exp_ov; v.exp_irq = exp_irq;
        return v;
    endfunction

    initial begin
        // Status word: in_count<<21 | out_count<<17 | irq_en<<4 | err_over<<3
        //              | err_under<<2 | out_full<<1 | in_empty
        vecs[0]  = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h1,      1, 0, 0);
        vecs[1]  = mk(AX,   0, 0, 0,     5, 1, 0, 0, 0,     0, 32'h1,      1, 0, 0);
        vecs[2]  = mk(AIn,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h5,      1, 0, 0);
        vecs[3]  = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h1,      1, 0, 0);
        vecs[4]  = mk(AIn,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h0,      1, 0, 0);
        vecs[5]  = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h5,      1, 0, 0);
        vecs[6]  = mk(ASt,  1, 0, 32'h4, 0, 0, 0, 0, 0,     0, 32'h5,      1, 0, 0);
        vecs[7]  = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h1,      1, 0, 0);
        vecs[8]  = mk(ASt,  1, 0, 32'h10, 7, 1, 0, 0, 0,    0, 32'h1,      1, 0, 1);
        vecs[9]  = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h200010, 1, 0, 1);
        vecs[10] = mk(AX,   0, 1, 0,     0, 0, 0, 0, 0,     0, 32'h200010, 1, 0, 1);
        vecs[11] = mk(AOut, 0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h0,      1, 0, 1);
        vecs[12] = mk(AIn,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h7,      1, 0, 0);
        vecs[13] = mk(AOut, 1, 0, 32'hAA, 0, 0, 0, 0, 0,    0, 32'h7,      1, 1, 0);
        vecs[14] = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h20011,  1, 1, 0);
        vecs[15] = mk(AX,   0, 0, 0,     0, 0, 1, 1, 32'hAA, 0, 32'h20011, 1, 0, 0);
        vecs[16] = mk(ASt,  1, 0, 32'h0, 0, 0, 0, 0, 0,     0, 32'h20011,  1, 0, 0);
        vecs[17] = mk(ASt,  0, 1, 0,     0, 0, 0, 0, 0,     1, 32'h1,      1, 0, 0);

        // Reset state
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_irq", bus_if.irq, 0);
        chk("rst_rdata", bus_if.bus_rdata, 0);
        chk("rst_oe", bus_if.bus_rdata_oe, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", bus_if.in_ready, 1);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            bus_if.address_bus = vecs[i].addr;
            bus_if.ram_write   = vecs[i].wr;
            bus_if.bus_rd      = vecs[i].rd;
            bus_if.bus_wdata   = vecs[i].wdata;
            bus_if.in_data     = vecs[i].idata;
            bus_if.in_valid    = vecs[i].ival;
            bus_if.out_ready   = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_oe", i), bus_if.bus_rdata_oe, vecs[i].exp_oe);
            if (vecs[i].chk_od) chk($sformatf("v%0d_out_data", i), bus_if.out_data, vecs[i].exp_od);
            tick();
            chk($sformatf("v%0d_rdata", i), bus_if.bus_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_in_ready", i), bus_if.in_ready, vecs[i].exp_ir);
            chk($sformatf("v%0d_out_valid", i), bus_if.out_valid, vecs[i].exp_ov);
            chk($sformatf("v%0d_irq", i), bus_if.irq, vecs[i].exp_irq);
        end
        idle();

        // Fill input FIFO past depth: ninth word must be held, not lost
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus_if.in_data = 100 + k;
            tick();
            chk($sformatf("fill%0d_in_ready", k), bus_if.in_ready, (k < 7) ? 1 : 0);
        end
        bus_if.in_data = 108;
        tick();
        chk("full_hold_in_ready", bus_if.in_ready, 0);
        cpu_rd(ASt);
        tick();
        chk("full_stat", bus_if.bus_rdata, 32'h01000000);
        cpu_rd(AIn);
        tick();
        chk("full_pop_first", bus_if.bus_rdata, 100);
        bus_if.bus_rd = 1'b0;
        tick();
        chk("held_word_pushed", bus_if.in_ready, 0);
        bus_if.in_valid = 1'b0;
        cpu_rd(AIn);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("drain_in%0d", k), bus_if.bus_rdata, 101 + k);
        end
        cpu_rd(ASt);
        tick();
        chk("drained_stat", bus_if.bus_rdata, 32'h1);
        idle();

        // Push and pop in the same cycle at count 3 across pointer wrap
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_if.in_data = 200 + k;
            tick();
        end
        cpu_rd(AIn);
        for (int k = 0; k < 10; k++) begin
            bus_if.in_data = 203 + k;
            tick();
            chk($sformatf("pushpop%0d", k), bus_if.bus_rdata, 200 + k);
        end
        bus_if.in_valid = 1'b0;
        cpu_rd(ASt);
        tick();
        chk("pushpop_stat", bus_if.bus_rdata, 32'h00600000);
        cpu_rd(AIn);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pushpop_tail%0d", k), bus_if.bus_rdata, 210 + k);
        end
        idle();

        // Output FIFO overflow then in-order drain
        for (int k = 1; k <= 9; k++) begin
            cpu_wr(AOut, k);
            tick();
        end
        cpu_rd(ASt);
        tick();
        chk("ovf_stat", bus_if.bus_rdata, 32'h0010000B);
        idle();
        bus_if.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("drain_out%0d_valid", k), bus_if.out_valid, 1);
            chk($sformatf("drain_out%0d_data", k), bus_if.out_data, k);
            tick();
        end
        chk("drain_out_empty", bus_if.out_valid, 0);
        bus_if.out_ready = 1'b0;
        cpu_wr(ASt, 32'h8);
        tick();
        cpu_rd(ASt);
        tick();
        chk("ovf_cleared_stat", bus_if.bus_rdata, 32'h1);
        idle();

        // Interrupt, then reset in the middle of traffic
        cpu_wr(ASt, 32'h10);
        tick();
        cpu_rd(AIn);
        tick();
        idle();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'h55;
        tick();
        chk("irq_on_push", bus_if.irq, 1);
        tick();
        bus_if.in_valid = 1'b0;
        cpu_wr(AOut, 32'h66);
        tick();
        chk("pre_rst_out_valid", bus_if.out_valid, 1);
        cpu_rd(ASt);
        tick();
        chk("pre_rst_stat", bus_if.bus_rdata, 32'h00420014);
        bus_if.in_valid = 1'b1;
        cpu_wr(AOut, 32'h77);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_in_ready", bus_if.in_ready, 0);
        chk("mid_rst_out_valid", bus_if.out_valid, 0);
        chk("mid_rst_irq", bus_if.irq, 0);
        chk("mid_rst_rdata", bus_if.bus_rdata, 0);
        idle();
        rst_n = 1'b1;
        tick();
        chk("after_rst_in_ready", bus_if.in_ready, 1);
        cpu_rd(ASt);
        tick();
        chk("after_rst_stat", bus_if.bus_rdata, 32'h1);
        chk("after_rst_irq", bus_if.irq, 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
